// File: rtl/encoder4to2_sync_pkg.sv
// Shared types and helpers for the registered 4-to-2 priority encoder.
package enc_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned W_IDX = 2;

    typedef logic [N_REQ-1:0] req_t;
    typedef logic [W_IDX-1:0] idx_t;

    // One-hot request vector that corresponds to a granted index.
    function automatic req_t onehot(idx_t i);
        return req_t'(1) << i;
    endfunction

endpackage

// File: rtl/encoder4to2_sync_if.sv
// Request-capture and grant handshake bundle of encoder4to2_sync.
interface encoder4to2_sync_if;
    import enc_pkg::*;

    logic E;
    req_t req;
    logic out_ready;
    idx_t idx;
    logic out_valid;
    req_t pending;

    modport master (
        output E, req, out_ready,
        input  idx, out_valid, pending
    );

    modport slave (
        input  E, req, out_ready,
        output idx, out_valid, pending
    );

endinterface

// File: rtl/encoder4to2_sync_prio_pick4.sv
// Combinational picker: first set bit of pending, searching downward cyclically from start.
module prio_pick4
    import enc_pkg::*;
(
    input  req_t pending,
    input  idx_t start,
    output idx_t sel,
    output logic any
);

    idx_t cand;

    // Walk from the lowest priority up so the highest priority match is written last.
    always_comb begin
        sel  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = start - idx_t'(k);
            if (pending[cand]) begin
                sel = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder4to2_sync.sv
// Registered 4-to-2 priority encoder with request capture and valid/ready output.
// Optional ENC_ROUND_ROBIN_EN rotates the search start past the last grant.
module encoder4to2_sync
    import enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    encoder4to2_sync_if.slave   bus
);

    req_t pending_q;
    idx_t idx_q;
    logic valid_q;

    idx_t start_c;
    idx_t sel_c;
    logic any_c;
    logic load_c;
    req_t grant_c;

`ifdef ENC_ROUND_ROBIN_EN
    idx_t last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (load_c && any_c) begin
            last_q <= sel_c;
        end
    end

    assign start_c = last_q - idx_t'(1);
`else
    assign start_c = idx_t'(3);
`endif

    prio_pick4 u_pick (
        .pending (pending_q),
        .start   (start_c),
        .sel     (sel_c),
        .any     (any_c)
    );

    assign load_c  = !valid_q || bus.out_ready;
    assign grant_c = (load_c && any_c) ? onehot(sel_c) : '0;

    // Grant clears its bit; a same-cycle request on that bit re-sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~grant_c) | (bus.req & {N_REQ{bus.E}});
            if (load_c) begin
                valid_q <= any_c;
                if (any_c) begin
                    idx_q <= sel_c;
                end
            end
        end
    end

    assign bus.pending   = pending_q;
    assign bus.idx       = idx_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_encoder4to2_sync.sv
// Directed self-checking bench for encoder4to2_sync, including a decoder2to4 round-trip model.
module tb_encoder4to2_sync;
    import enc_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    encoder4to2_sync_if bus ();

    encoder4to2_sync dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder2to4 fed with A=idx, E=out_valid.
    function automatic logic [3:0] dec_o(logic [1:0] a, logic e);
        logic [3:0] one;
        one = 4'b0001;
        return e ? (one << a) : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] i, input logic [3:0] p);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) check({tag, ".idx"}, 32'(bus.idx), 32'(i));
        check({tag, ".pend"}, 32'(bus.pending), 32'(p));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] rr_exp [5];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.E = 1'b0;
        bus.req = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset.idx", 32'(bus.idx), 32'd0);
        chk_out("reset", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        tick();

        // Build pending=1010 with a stalled grant, then reset mid-cycle.
        bus.E = 1'b1; bus.req = 4'b1010; bus.out_ready = 1'b0;
        tick();
        tick();
        bus.req = 4'b0000;
        chk_out("pre_rst", 1'b1, 2'd3, 4'b1010);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 4'b0000);
        check("async_rst.idx", 32'(bus.idx), 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        chk_out("post_rst", 1'b0, 2'd0, 4'b0000);

        // Multi-hot single-cycle request drains highest first.
        bus.req = 4'b1011;
        tick();
        bus.req = 4'b0000;
        chk_out("burst.cap", 1'b0, 2'd0, 4'b1011);
        tick();
        chk_out("burst.g3", 1'b1, 2'd3, 4'b0011);
        check("burst.dec3", 32'(dec_o(bus.idx, bus.out_valid)), 32'(4'b1000));
        tick();
        chk_out("burst.g1", 1'b1, 2'd1, 4'b0001);
        check("burst.dec1", 32'(dec_o(bus.idx, bus.out_valid)), 32'(4'b0010));
        tick();
        chk_out("burst.g0", 1'b1, 2'd0, 4'b0000);
        check("burst.dec0", 32'(dec_o(bus.idx, bus.out_valid)), 32'(4'b0001));
        tick();
        chk_out("burst.empty", 1'b0, 2'd0, 4'b0000);

        // Stall holds the grant; one accept then drop.
        bus.out_ready = 1'b0;
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk_out($sformatf("stall%0d", c), 1'b1, 2'd2, 4'b0000);
            tick();
        end
        bus.out_ready = 1'b1;
        check("stall.dec", 32'(dec_o(bus.idx, bus.out_valid)), 32'(4'b0100));
        tick();
        chk_out("stall.done", 1'b0, 2'd0, 4'b0000);
        check("stall.idx_hold", 32'(bus.idx), 32'd2);

        // Capture disabled ignores requests.
        bus.E = 1'b0; bus.req = 4'b1111;
        tick(); tick(); tick();
        chk_out("e0", 1'b0, 2'd0, 4'b0000);
        bus.E = 1'b1; bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        chk_out("e1.cap", 1'b0, 2'd0, 4'b0001);
        tick();
        chk_out("e1.g0", 1'b1, 2'd0, 4'b0000);
        tick();
        chk_out("e1.empty", 1'b0, 2'd0, 4'b0000);

        // Same-cycle re-request on the bit being granted survives.
        bus.req = 4'b0010;
        tick();
        chk_out("rereq.cap", 1'b0, 2'd0, 4'b0010);
        tick();
        bus.req = 4'b0000;
        chk_out("rereq.g1a", 1'b1, 2'd1, 4'b0010);
        tick();
        chk_out("rereq.g1b", 1'b1, 2'd1, 4'b0000);
        tick();
        chk_out("rereq.empty", 1'b0, 2'd0, 4'b0000);

        // Held all-request: rotation order or fixed priority.
`ifdef ENC_ROUND_ROBIN_EN
        rr_exp[0] = 2'd3; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1; rr_exp[3] = 2'd0; rr_exp[4] = 2'd3;
`else
        rr_exp[0] = 2'd3; rr_exp[1] = 2'd3; rr_exp[2] = 2'd3; rr_exp[3] = 2'd3; rr_exp[4] = 2'd3;
`endif
        do_reset();
        bus.E = 1'b1; bus.out_ready = 1'b1; bus.req = 4'b1111;
        tick();
        chk_out("all.cap", 1'b0, 2'd0, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out($sformatf("all.g%0d", c), 1'b1, rr_exp[c], 4'b1111);
            check($sformatf("all.dec%0d", c), 32'(dec_o(bus.idx, bus.out_valid)), 32'(onehot(rr_exp[c])));
        end
        bus.req = 4'b0000;
        bus.E = 1'b0;
        tick();
        check("all.drain.valid", 32'(bus.out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
